// File: rtl/menu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : menu_pkg
// Description : Shared definitions for the pet UI menu. Holds the menu
//               controller state encoding and the icon index constants that
//               the action engine uses to decode acao_id.
// Revision    : 1.0 - initial release
// ============================================================================
package menu_pkg;

    // Menu controller states. All four 2-bit codes are in use.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,   // menu hidden
        ST_NAVEGA   = 2'd1,   // menu visible, cursor moving
        ST_EXECUTA  = 2'd2,   // action request pending on the handshake
        ST_AGUARDA  = 2'd3    // waiting for the action engine to go idle
    } estado_t;

    // Icon indices, in on-screen order. The action engine decodes acao_id
    // against these same values.
    localparam int ITEM_COMIDA  = 0;
    localparam int ITEM_BRINCAR = 1;
    localparam int ITEM_LIMPAR  = 2;
    localparam int ITEM_DORMIR  = 3;
    localparam int ITEM_REMEDIO = 4;
    localparam int ITEM_BANHO   = 5;
    localparam int ITEM_STATUS  = 6;
    localparam int ITEM_LUZ     = 7;

endpackage : menu_pkg
`default_nettype wire

// File: rtl/contador_timeout.sv
`default_nettype none
// ============================================================================
// Module      : contador_timeout
// Description : Inactivity counter for the menu. Counts while enabled,
//               returns to zero when cleared or disabled, and raises expira
//               during the cycle in which the count sits at TIMEOUT_CICLOS-1
//               with no clear, so the owner can leave on that edge.
// Ports       : clk, rst_n (async, active-low)
//               clear   in  1  any button press this cycle
//               enable  in  1  counting window (menu open)
//               expira  out 1  inactivity limit reached this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module contador_timeout #(
    parameter int TIMEOUT_CICLOS = 12_000_000,
    parameter int TIMEOUT_W      = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expira
);

    localparam logic [TIMEOUT_W-1:0] C_LIMITE = TIMEOUT_W'(TIMEOUT_CICLOS - 1);

    logic [TIMEOUT_W-1:0] r_contagem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_contagem <= '0;
        end else if (clear || !enable) begin
            r_contagem <= '0;
        end else begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    // A press on the same edge wins over the timeout.
    assign expira = enable && !clear && (r_contagem == C_LIMITE);

endmodule : contador_timeout
`default_nettype wire

// File: rtl/controlador_menu.sv
`default_nettype none
// ============================================================================
// Module      : controlador_menu
// Description : Menu navigation controller for the three-button pet UI.
//               Turns debounced one-cycle button pulses into a wrapping
//               cursor over N_ITENS icons, issues a valid/ready action
//               request on confirm, then locks out input until the action
//               engine reports idle.
// Ports       : clk, rst_n (async, active-low)
//               btn_sel / btn_ok / btn_cancel  in   1  one-cycle press pulses
//               acao_ready                     in   1  engine accepts request
//               busy                           in   1  engine executing
//               menu_ativo                     out  1  menu visible
//               cursor                         out  W  highlighted icon
//               acao_valid                     out  1  request pending
//               acao_id                        out  W  requested icon
//               (W = $clog2(N_ITENS); all outputs registered)
// Options     : MENU_TIMEOUT_EN - when defined, the menu closes after
//               TIMEOUT_CICLOS cycles without a press.
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_menu
    import menu_pkg::*;
#(
    parameter int N_ITENS        = 8,
    parameter int TIMEOUT_CICLOS = 12_000_000,
    parameter int TIMEOUT_W      = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       btn_sel,
    input  logic                       btn_ok,
    input  logic                       btn_cancel,
    input  logic                       acao_ready,
    input  logic                       busy,
    output logic                       menu_ativo,
    output logic [$clog2(N_ITENS)-1:0] cursor,
    output logic                       acao_valid,
    output logic [$clog2(N_ITENS)-1:0] acao_id
);

    localparam int               C_CW     = $clog2(N_ITENS);
    localparam logic [C_CW-1:0]  C_ULTIMO = C_CW'(N_ITENS - 1);

    estado_t          r_estado;
    estado_t          w_estado_prox;
    logic [C_CW-1:0]  r_cursor;
    logic [C_CW-1:0]  w_cursor_prox;
    logic [C_CW-1:0]  r_acao_id;
    logic [C_CW-1:0]  w_acao_id_prox;
    logic             r_menu_ativo;
    logic             r_acao_valid;

    // Priority resolution: cancel > ok > sel; only the winner is acted on.
    logic w_press_cancel;
    logic w_press_ok;
    logic w_press_sel;
    logic w_press_any;
    logic w_expira;

    assign w_press_cancel = btn_cancel;
    assign w_press_ok     = btn_ok  && !btn_cancel;
    assign w_press_sel    = btn_sel && !btn_ok && !btn_cancel;
    assign w_press_any    = btn_sel || btn_ok || btn_cancel;

`ifdef MENU_TIMEOUT_EN
    contador_timeout #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_contador_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_press_any),
        .enable (r_estado == ST_NAVEGA),
        .expira (w_expira)
    );
`else
    // No inactivity limit: the menu stays open until cancel or ok.
    assign w_expira = 1'b0;

    // Keeps the timeout parameters referenced when the feature is absent.
    generate
        if (TIMEOUT_CICLOS < 1 || TIMEOUT_W < 1) begin : g_timeout_sem_uso
        end
    endgenerate
`endif

    // Next-state, cursor and action id.
    always_comb begin
        w_estado_prox  = r_estado;
        w_cursor_prox  = r_cursor;
        w_acao_id_prox = r_acao_id;

        case (r_estado)
            ST_IDLE: begin
                // Opening press is consumed; it never moves the cursor.
                if (w_press_any) begin
                    w_estado_prox = ST_NAVEGA;
                    w_cursor_prox = '0;
                end
            end

            ST_NAVEGA: begin
                if (w_press_cancel) begin
                    w_estado_prox = ST_IDLE;
                end else if (w_press_ok) begin
                    w_estado_prox  = ST_EXECUTA;
                    w_acao_id_prox = r_cursor;
                end else if (w_press_sel) begin
                    w_cursor_prox = (r_cursor == C_ULTIMO) ? '0 : r_cursor + 1'b1;
                end else if (w_expira) begin
                    w_estado_prox = ST_IDLE;
                end
            end

            ST_EXECUTA: begin
                // Request cannot be withdrawn; buttons are ignored here.
                if (r_acao_valid && acao_ready) begin
                    w_estado_prox = ST_AGUARDA;
                end
            end

            ST_AGUARDA: begin
                if (!busy) begin
                    w_estado_prox = ST_IDLE;
                end
            end

            default: begin
                w_estado_prox = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Outputs are decoded from the next state so
    // they change on the same edge as the state, with no input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado     <= ST_IDLE;
            r_cursor     <= '0;
            r_acao_id    <= '0;
            r_menu_ativo <= 1'b0;
            r_acao_valid <= 1'b0;
        end else begin
            r_estado     <= w_estado_prox;
            r_cursor     <= w_cursor_prox;
            r_acao_id    <= w_acao_id_prox;
            r_menu_ativo <= (w_estado_prox == ST_NAVEGA);
            r_acao_valid <= (w_estado_prox == ST_EXECUTA);
        end
    end

    assign menu_ativo = r_menu_ativo;
    assign cursor     = r_cursor;
    assign acao_valid = r_acao_valid;
    assign acao_id    = r_acao_id;

endmodule : controlador_menu
`default_nettype wire
